// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-wide block RAM between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int RAM_AW = 11,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rsp_valid,
  output logic [31:0]       o_if_rsp_data,
  output logic              o_if_err,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [1:0]        i_ls_size,
  input  logic [31:0]       i_ls_addr,
  input  logic [31:0]       i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rsp_valid,
  output logic [31:0]       o_ls_rsp_data,
  output logic              o_ls_err,
  output logic              o_ram_clk_en,
  output logic              o_ram_read_enable,
  output logic [RAM_AW-1:0] o_ram_read_addr,
  output logic [3:0]        o_ram_write_enable,
  output logic [3:0]        o_ram_byte_enable,
  output logic [RAM_AW-1:0] o_ram_write_addr,
  output logic [31:0]       o_ram_write_data,
  input  logic [31:0]       i_ram_read_data
);
  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);
  typedef enum logic [2:0] {IDLE, RD_IF, RD_LS, WR_ACK, ERR_IF, ERR_LS} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic if_win, ls_win, if_bad, ls_bad, rd_if, rd_ls, wr_ls;
  logic [3:0] be;
  logic [31:0] wdata_rep;
  logic [RAM_AW-1:0] if_waddr, ls_waddr;
  assign if_waddr = i_if_addr[RAM_AW+1:2];
  assign ls_waddr = i_ls_addr[RAM_AW+1:2];
  assign if_bad = (i_if_addr[1:0] != 2'b00) || (i_if_addr[31:RAM_AW+2] != '0);
  assign ls_bad = (i_ls_size == 2'b11) || (i_ls_size == 2'b01 && i_ls_addr[0])
               || (i_ls_size == 2'b10 && i_ls_addr[1:0] != 2'b00) || (i_ls_addr[31:RAM_AW+2] != '0);
  // LS has priority until IF has waited out the full streak; nothing is granted while in reset
  assign ls_win = rst && state == IDLE && i_ls_req && !(i_if_req && streak == STREAK_MAX);
  assign if_win = rst && state == IDLE && i_if_req && !ls_win;
  assign rd_if = if_win && !if_bad;
  assign rd_ls = ls_win && !ls_bad && !i_ls_we;
  assign wr_ls = ls_win && !ls_bad && i_ls_we;
  assign be = i_ls_size == 2'b00 ? 4'b0001 << i_ls_addr[1:0]
            : i_ls_size == 2'b01 ? 4'b0011 << i_ls_addr[1:0] : 4'b1111;
  assign wdata_rep = i_ls_size == 2'b00 ? {4{i_ls_wdata[7:0]}}
                   : i_ls_size == 2'b01 ? {2{i_ls_wdata[15:0]}} : i_ls_wdata;
  // state and fairness-streak registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end
  // every grant leads to a one-cycle response state; the streak only counts LS wins that made IF wait
  always_comb begin
    state_nxt  = IDLE;
    streak_nxt = streak;
    if (if_win) begin
      state_nxt  = if_bad ? ERR_IF : RD_IF;
      streak_nxt = '0;
    end else if (ls_win) begin
      state_nxt  = ls_bad ? ERR_LS : i_ls_we ? WR_ACK : RD_LS;
      streak_nxt = !i_if_req ? '0 : streak == STREAK_MAX ? streak : streak + SW'(1);
    end else if (state == IDLE && !i_if_req) begin
      streak_nxt = '0;
    end
  end
  // RAM strobes only on legal grants; responses decoded from the response state
  always_comb begin
    o_if_gnt           = if_win;
    o_ls_gnt           = ls_win;
    o_ram_read_enable  = rd_if || rd_ls;
    o_ram_clk_en       = rd_if || rd_ls;
    o_ram_read_addr    = rd_if ? if_waddr : rd_ls ? ls_waddr : '0;
    o_ram_write_enable = wr_ls ? be : 4'b0000;
    o_ram_byte_enable  = wr_ls ? be : 4'b0000;
    o_ram_write_addr   = wr_ls ? ls_waddr : '0;
    o_ram_write_data   = wr_ls ? wdata_rep : 32'h0;
    o_if_rsp_valid     = state == RD_IF || state == ERR_IF;
    o_if_rsp_data      = state == RD_IF ? i_ram_read_data : 32'h0;
    o_if_err           = state == ERR_IF;
    o_ls_rsp_valid     = state == RD_LS || state == WR_ACK || state == ERR_LS;
    o_ls_rsp_data      = state == RD_LS ? i_ram_read_data : 32'h0;
    o_ls_err           = state == ERR_LS;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 0;
  logic rst = 0;
  logic i_if_req = 0, i_ls_req = 0, i_ls_we = 0;
  logic [31:0] i_if_addr = 0, i_ls_addr = 0, i_ls_wdata = 0;
  logic [1:0] i_ls_size = 0;
  logic o_if_gnt, o_if_rsp_valid, o_if_err, o_ls_gnt, o_ls_rsp_valid, o_ls_err;
  logic [31:0] o_if_rsp_data, o_ls_rsp_data, o_ram_write_data;
  logic o_ram_clk_en, o_ram_read_enable;
  logic [10:0] o_ram_read_addr, o_ram_write_addr;
  logic [3:0] o_ram_write_enable, o_ram_byte_enable;
  logic [31:0] rdata = 0;
  logic [31:0] ram [0:2047];
  typedef struct {logic ls; logic [31:0] data; logic err;} rsp_t;
  rsp_t q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RAM_AW(11), .DATA_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rsp_valid(o_if_rsp_valid), .o_if_rsp_data(o_if_rsp_data), .o_if_err(o_if_err),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_size(i_ls_size), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt), .o_ls_rsp_valid(o_ls_rsp_valid),
    .o_ls_rsp_data(o_ls_rsp_data), .o_ls_err(o_ls_err),
    .o_ram_clk_en(o_ram_clk_en), .o_ram_read_enable(o_ram_read_enable),
    .o_ram_read_addr(o_ram_read_addr), .o_ram_write_enable(o_ram_write_enable),
    .o_ram_byte_enable(o_ram_byte_enable), .o_ram_write_addr(o_ram_write_addr),
    .o_ram_write_data(o_ram_write_data), .i_ram_read_data(rdata)
  );

  // RAM model: preloaded while in reset, registered read, per-lane write
  always @(posedge clk) begin
    if (!rst) begin
      ram[0] <= 32'hAABBCCDD;
      ram[1] <= 32'h11223344;
      ram[4] <= 32'hDEADBEEF;
    end else begin
      if (o_ram_read_enable) rdata <= ram[o_ram_read_addr];
      for (int b = 0; b < 4; b++)
        if (o_ram_write_enable[b]) ram[o_ram_write_addr][8*b +: 8] <= o_ram_write_data[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobes(string tag, logic re, logic [10:0] ra, logic [3:0] wen,
                         logic [10:0] wa, logic [31:0] wd);
    chk({tag, "_re"}, 32'(o_ram_read_enable), 32'(re));
    chk({tag, "_clken"}, 32'(o_ram_clk_en), 32'(re));
    chk({tag, "_ra"}, 32'(o_ram_read_addr), 32'(ra));
    chk({tag, "_we"}, 32'(o_ram_write_enable), 32'(wen));
    chk({tag, "_be"}, 32'(o_ram_byte_enable), 32'(wen));
    chk({tag, "_wa"}, 32'(o_ram_write_addr), 32'(wa));
    chk({tag, "_wd"}, o_ram_write_data, wd);
  endtask

  task automatic push(logic ls, logic [31:0] data, logic err);
    rsp_t e;
    e.ls = ls;
    e.data = data;
    e.err = err;
    q.push_back(e);
  endtask

  task automatic check_rsp(string tag);
    rsp_t e;
    chk({tag, "_rgnt"}, 32'({o_if_gnt, o_ls_gnt}), 32'h0);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_rvalid"}, 32'({o_if_rsp_valid, o_ls_rsp_valid}), e.ls ? 32'h1 : 32'h2);
      chk({tag, "_rdata"}, e.ls ? o_ls_rsp_data : o_if_rsp_data, e.data);
      chk({tag, "_rerr"}, 32'(e.ls ? o_ls_err : o_if_err), 32'(e.err));
    end else begin
      chk({tag, "_rvalid"}, 32'({o_if_rsp_valid, o_ls_rsp_valid}), 32'h0);
    end
  endtask

  task automatic ls_access(string tag, logic we, logic [1:0] size, logic [31:0] addr,
                           logic [31:0] wdata, logic re, logic [10:0] ra, logic [3:0] wen,
                           logic [10:0] wa, logic [31:0] wd, logic [31:0] rd, logic er);
    @(posedge clk); #1;
    i_ls_req = 1; i_ls_we = we; i_ls_size = size; i_ls_addr = addr; i_ls_wdata = wdata;
    push(1'b1, rd, er);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'({o_if_gnt, o_ls_gnt}), 32'h1);
    strobes(tag, re, ra, wen, wa, wd);
    @(posedge clk); #1;
    i_ls_req = 0;
    @(negedge clk);
    check_rsp(tag);
  endtask

  task automatic if_access(string tag, logic [31:0] addr, logic re, logic [10:0] ra,
                           logic [31:0] rd, logic er);
    @(posedge clk); #1;
    i_if_req = 1; i_if_addr = addr;
    push(1'b0, rd, er);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'({o_if_gnt, o_ls_gnt}), 32'h2);
    strobes(tag, re, ra, 4'b0000, 11'd0, 32'h0);
    @(posedge clk); #1;
    i_if_req = 0;
    @(negedge clk);
    check_rsp(tag);
  endtask

  task automatic run_seq(string tag, int n, logic [15:0] ifp, logic [15:0] winif, logic [31:0] ls_exp);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      i_if_req = ifp[k]; i_if_addr = 32'h10;
      i_ls_req = 1; i_ls_we = 0; i_ls_size = 2'b10; i_ls_addr = 32'h4;
      if (winif[k]) push(1'b0, 32'hCAFEF00D, 1'b0);
      else push(1'b1, ls_exp, 1'b0);
      @(negedge clk);
      chk($sformatf("%s_slot%0d", tag, k), 32'({o_if_gnt, o_ls_gnt}), winif[k] ? 32'h2 : 32'h1);
      @(posedge clk); #1;
      i_if_req = 0; i_ls_req = 0;
      @(negedge clk);
      check_rsp($sformatf("%s_rsp%0d", tag, k));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    i_if_req = 1; i_ls_req = 1; i_if_addr = 32'h10; i_ls_addr = 32'h4; i_ls_size = 2'b10;
    @(negedge clk);
    chk("rst_gnt", 32'({o_if_gnt, o_ls_gnt}), 32'h0);
    chk("rst_valid", 32'({o_if_rsp_valid, o_ls_rsp_valid, o_if_err, o_ls_err}), 32'h0);
    strobes("rst", 1'b0, 11'd0, 4'b0000, 11'd0, 32'h0);
    @(posedge clk); #1;
    i_if_req = 0; i_ls_req = 0;
    rst = 1;
    @(posedge clk); #1;
    i_ls_req = 1; i_ls_we = 0;
    @(negedge clk);
    chk("midrd_gnt", 32'({o_if_gnt, o_ls_gnt}), 32'h1);
    @(posedge clk); #1;
    i_ls_req = 0;
    chk("midrd_valid", 32'(o_ls_rsp_valid), 32'h1);
    chk("midrd_data", o_ls_rsp_data, 32'h11223344);
    rst = 0;
    i_if_req = 1;
    #1;
    chk("midrd_rst_valid", 32'({o_if_rsp_valid, o_ls_rsp_valid, o_if_err, o_ls_err}), 32'h0);
    chk("midrd_rst_data", o_ls_rsp_data | o_if_rsp_data, 32'h0);
    chk("midrd_rst_gnt", 32'({o_if_gnt, o_ls_gnt}), 32'h0);
    chk("midrd_rst_re", 32'(o_ram_read_enable), 32'h0);
    @(posedge clk); #1;
    rst = 1;
    i_if_req = 0;
    @(negedge clk);
    check_rsp("post_rst");
    if_access("if_rd10", 32'h10, 1'b1, 11'd4, 32'hDEADBEEF, 1'b0);
    ls_access("st_byte6", 1'b1, 2'b00, 32'h6, 32'hA5, 1'b0, 11'd0, 4'b0100, 11'd1, 32'hA5A5A5A5, 32'h0, 1'b0);
    ls_access("st_half2", 1'b1, 2'b01, 32'h2, 32'h1234, 1'b0, 11'd0, 4'b1100, 11'd0, 32'h12341234, 32'h0, 1'b0);
    ls_access("ld_word4", 1'b0, 2'b10, 32'h4, 32'h0, 1'b1, 11'd1, 4'b0000, 11'd0, 32'h0, 32'h11A53344, 1'b0);
    ls_access("ld_word0", 1'b0, 2'b10, 32'h0, 32'h0, 1'b1, 11'd0, 4'b0000, 11'd0, 32'h0, 32'h1234CCDD, 1'b0);
    ls_access("ld_byte5", 1'b0, 2'b00, 32'h5, 32'h0, 1'b1, 11'd1, 4'b0000, 11'd0, 32'h0, 32'h11A53344, 1'b0);
    ls_access("st_word10", 1'b1, 2'b10, 32'h10, 32'hCAFEF00D, 1'b0, 11'd0, 4'b1111, 11'd4, 32'hCAFEF00D, 32'h0, 1'b0);
    if_access("if_rd10b", 32'h10, 1'b1, 11'd4, 32'hCAFEF00D, 1'b0);
    ls_access("err_half3", 1'b0, 2'b01, 32'h3, 32'h0, 1'b0, 11'd0, 4'b0000, 11'd0, 32'h0, 32'h0, 1'b1);
    ls_access("err_size3", 1'b0, 2'b11, 32'h0, 32'h0, 1'b0, 11'd0, 4'b0000, 11'd0, 32'h0, 32'h0, 1'b1);
    ls_access("err_word2", 1'b1, 2'b10, 32'h2, 32'h55, 1'b0, 11'd0, 4'b0000, 11'd0, 32'h0, 32'h0, 1'b1);
    ls_access("err_st_oor", 1'b1, 2'b10, 32'h4000, 32'h55, 1'b0, 11'd0, 4'b0000, 11'd0, 32'h0, 32'h0, 1'b1);
    if_access("err_if_oor", 32'h10000, 1'b0, 11'd0, 32'h0, 1'b1);
    if_access("err_if_mis", 32'h2, 1'b0, 11'd0, 32'h0, 1'b1);
    ls_access("ld_last", 1'b0, 2'b10, 32'h1FFC, 32'h0, 1'b1, 11'h7FF, 4'b0000, 11'd0, 32'h0, ram[2047], 1'b0);
    run_seq("prio", 10, 16'h03FF, 16'h0210, 32'h11A53344);
    run_seq("drop", 8, 16'h00FB, 16'h0080, 32'h11A53344);
    chk("q_empty", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
